// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: gathers a serial stream of DATA_W-bit samples into
// 8-sample frames and presents each complete frame in parallel on A0..A7.
// Two banks ping-pong, so one frame can fill while the other is held
// stable for the downstream FFT and its consumer.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Valid never depends on ready on the same side.
// The source must hold in_data/in_valid while in_ready is low. A0..A7 stay
// stable while out_valid is high until the consumer raises out_ready.
module fft8_frame_loader #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A0,
  output logic [DATA_W-1:0] A1,
  output logic [DATA_W-1:0] A2,
  output logic [DATA_W-1:0] A3,
  output logic [DATA_W-1:0] A4,
  output logic [DATA_W-1:0] A5,
  output logic [DATA_W-1:0] A6,
  output logic [DATA_W-1:0] A7,
  output logic [2:0]        wr_idx,
  output logic [CNT_W-1:0]  frame_count
);

  logic [DATA_W-1:0] bank [0:1][0:7];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic              accept;
  logic              consume;

  // The write bank is free whenever it is not still waiting to be consumed.
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  // flush wins over a sample offered in the same cycle.
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;

  // Sample storage: the accepted sample lands in the next free slot of the fill bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else if (accept) begin
      bank[wr_bank][wr_idx] <= in_data;
    end
  end

  // Pointer and full-flag bookkeeping. Completion and consume always touch
  // different banks: completion needs full[wr_bank]=0, consume needs full[rd_bank]=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= 3'd0;
      frame_count <= '0;
    end else begin
      if (flush) begin
        wr_idx <= 3'd0;
      end else if (accept) begin
        if (wr_idx == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= 3'd0;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        frame_count   <= frame_count + CNT_W'(1);
      end
    end
  end

  // The read bank drives the frame outputs directly from registers.
  assign A0 = bank[rd_bank][0];
  assign A1 = bank[rd_bank][1];
  assign A2 = bank[rd_bank][2];
  assign A3 = bank[rd_bank][3];
  assign A4 = bank[rd_bank][4];
  assign A5 = bank[rd_bank][5];
  assign A6 = bank[rd_bank][6];
  assign A7 = bank[rd_bank][7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader: directed phases plus randomized traffic,
// reference model of frames/occupancy, and a scoreboard of expected frames.
module tb_fft8_frame_loader;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int FW  = 8 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          flush    = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [2:0]    wr_idx;
  logic [CW-1:0] frame_count;

  // second instance with a 2-bit counter to see the counter wrap
  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [2:0]    s_wr_idx;
  logic [1:0]    s_frame_count;

  fft8_frame_loader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .A0(a0), .A1(a1), .A2(a2), .A3(a3), .A4(a4),
    .A5(a5), .A6(a6), .A7(a7), .wr_idx(wr_idx), .frame_count(frame_count)
  );

  fft8_frame_loader #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .A0(s0), .A1(s1), .A2(s2), .A3(s3), .A4(s4),
    .A5(s5), .A6(s6), .A7(s7), .wr_idx(s_wr_idx), .frame_count(s_frame_count)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [FW-1:0] dut_frame();
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // ---------------- reference model ----------------
  // Frames in flight (0..2), samples gathered for the current frame and
  // number of frames delivered. Inputs are stable at the falling edge and
  // are the ones the next rising edge will act on.
  int            pending = 0;
  int            cur_n   = 0;
  int            fcount  = 0;
  logic [DW-1:0] cur [8];

  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      cur_n   = 0;
      fcount  = 0;
      exp_q.delete();
    end else begin
      logic m_ready, m_valid, acc, cons;
      logic [FW-1:0] f;
      m_ready = (pending < 2);
      m_valid = (pending > 0);
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("wr_idx", 64'(wr_idx), 64'(cur_n));
      chk("frame_count", 64'(frame_count), 64'(fcount % 65536));
      chk("frame_count_w2", 64'(s_frame_count), 64'(fcount % 4));
      acc  = in_valid && m_ready && !flush;
      cons = m_valid && out_ready;
      if (flush) begin
        cur_n = 0;
      end else if (acc) begin
        cur[cur_n] = in_data;
        cur_n++;
        if (cur_n == 8) begin
          for (int i = 0; i < 8; i++) f[i*DW +: DW] = cur[i];
          exp_q.push_back(f);
          pending++;
          cur_n = 0;
        end
      end
      if (cons) begin
        pending--;
        fcount++;
      end
    end
  end

  // ---------------- monitor ----------------
  // Whenever a frame is presented, it must equal the oldest expected frame;
  // it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame: got %0h expected no frame at %0t", dut_frame(), $time);
      end else begin
        if (dut_frame() !== exp_q[0]) begin
          bad++;
          for (int i = 0; i < 8; i++) begin
            if (dut_frame() >> (i*DW) != exp_q[0] >> (i*DW)) begin
              $display("FAIL frame A%0d: got %0h expected %0h at %0t", i,
                       dut_frame()[i*DW +: DW], exp_q[0][i*DW +: DW], $time);
              break;
            end
          end
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rnd_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one sample and hold it until it is taken (bounded).
  task automatic send(input logic [DW-1:0] d);
    logic taken;
    int   budget;
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    taken    = 1'b0;
    while (!taken) begin
      @(negedge clk);
      taken = in_ready;
      step();
      budget++;
      if (!taken && budget > 40) begin
        chk("send_timeout", 64'(budget), 64'(0));
        taken = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_A0", 64'(a0), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    step();
    step();
    rst = 1'b0;
    step();

    // two frames with the consumer stalled, then a single-cycle take
    for (int n = 1; n <= 16; n++) send(DW'(n));
    idle(2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(3);

    // continuous stream with the consumer always ready
    for (int n = 0; n < 32; n++) send(DW'(32'h100 + n));
    idle(3);

    // flush alongside the 6th sample
    for (int n = 0; n < 5; n++) send(DW'(32'h50 + n));
    in_valid = 1'b1;
    in_data  = 32'h55;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    for (int n = 0; n < 8; n++) send(DW'(32'hA0 + n));
    idle(3);

    // asynchronous reset mid-frame with a full bank pending
    out_ready = 1'b0;
    for (int n = 0; n < 11; n++) send(DW'(32'h300 + n));
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_A0", 64'(a0), 64'(0));
    chk("arst_A7", 64'(a7), 64'(0));
    chk("arst_frame_count", 64'(frame_count), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_wr_idx", 64'(wr_idx), 64'(0));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) send(DW'(32'h400 + n));

    // negative samples, bit-exact
    for (int n = 0; n < 8; n++) send(32'hFFFF_FFF8 + 32'(n));
    idle(3);

    // randomized traffic: gaps, random consumer, occasional flush
    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        send($urandom);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(20);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
